// File: rtl/count_load_sequencer.sv
// rtl/count_load_sequencer.sv - command stage that presets the loadable counter and runs it to a stop value
// Optional RUN-state watchdog with err output: define CNT_SEQ_WDOG_EN.
module count_load_sequencer #(
    parameter int WIDTH  = 8,
    parameter int LOAD_W = 3
`ifdef CNT_SEQ_WDOG_EN
    ,
    parameter int WDOG_CYCLES = 256
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WIDTH-1:0]  cmd_start,
    input  logic [WIDTH-1:0]  cmd_stop,
    input  logic [LOAD_W-1:0] cmd_mode,
    input  logic              abort,
    input  logic [WIDTH-1:0]  cnt,
    output logic              ena,
    output logic [LOAD_W-1:0] load,
    output logic [WIDTH-1:0]  data,
    output logic              busy,
    output logic              done
`ifdef CNT_SEQ_WDOG_EN
    ,
    output logic              err
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_S = 2'd1,
        RUN    = 2'd2,
        DONE_S = 2'd3
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  stop_q;
    logic [LOAD_W-1:0] mode_eff;

`ifdef CNT_SEQ_WDOG_EN
    localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
    logic [WDOG_W-1:0] wdog_cnt;
`endif

    // A zero load code would mean "no load", so it is promoted to 1.
    assign mode_eff = (cmd_mode == '0) ? LOAD_W'(1) : cmd_mode;

    // Enable is combinational so the counter stops on the very edge it reaches stop.
    assign ena = (state == RUN) && (cnt != stop_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            load      <= '0;
            data      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            stop_q    <= '0;
`ifdef CNT_SEQ_WDOG_EN
            wdog_cnt  <= '0;
            err       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef CNT_SEQ_WDOG_EN
            err  <= 1'b0;
`endif
            if (abort) begin
                state     <= IDLE;
                cmd_ready <= 1'b1;
                load      <= '0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cmd_ready <= 1'b1;
                        if (cmd_valid && cmd_ready) begin
                            state     <= LOAD_S;
                            cmd_ready <= 1'b0;
                            load      <= mode_eff;
                            data      <= cmd_start;
                            stop_q    <= cmd_stop;
                            busy      <= 1'b1;
                        end
                    end
                    LOAD_S: begin
                        load  <= '0;
                        state <= RUN;
`ifdef CNT_SEQ_WDOG_EN
                        wdog_cnt <= '0;
`endif
                    end
                    RUN: begin
                        if (cnt == stop_q) begin
                            state <= DONE_S;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
`ifdef CNT_SEQ_WDOG_EN
                        else if (wdog_cnt == WDOG_LAST) begin
                            state     <= IDLE;
                            err       <= 1'b1;
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                        end else begin
                            wdog_cnt <= wdog_cnt + 1'b1;
                        end
`endif
                    end
                    DONE_S: begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_load_sequencer.sv
// tb/tb_count_load_sequencer.sv - self-checking bench for count_load_sequencer with a behavioural counter
module tb_count_load_sequencer;
    localparam int WIDTH  = 8;
    localparam int LOAD_W = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic cmd_valid = 1'b0;
    logic abort = 1'b0;
    logic cnt_stuck = 1'b0;
    logic [WIDTH-1:0]  cmd_start = '0;
    logic [WIDTH-1:0]  cmd_stop = '0;
    logic [LOAD_W-1:0] cmd_mode = '0;
    logic cmd_ready, ena, busy, done;
    logic [WIDTH-1:0]  cnt_model, cnt, data;
    logic [LOAD_W-1:0] load;
`ifdef CNT_SEQ_WDOG_EN
    logic err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // Downstream loadable up-counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset)            cnt_model <= '0;
        else if (load != '0)  cnt_model <= data;
        else if (ena)         cnt_model <= cnt_model + 1'b1;
    end
    assign cnt = cnt_stuck ? '0 : cnt_model;

    count_load_sequencer #(
        .WIDTH(WIDTH),
        .LOAD_W(LOAD_W)
`ifdef CNT_SEQ_WDOG_EN
        ,
        .WDOG_CYCLES(16)
`endif
    ) dut (
        .clock(clock),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_start(cmd_start),
        .cmd_stop(cmd_stop),
        .cmd_mode(cmd_mode),
        .abort(abort),
        .cnt(cnt),
        .ena(ena),
        .load(load),
        .data(data),
        .busy(busy),
        .done(done)
`ifdef CNT_SEQ_WDOG_EN
        ,
        .err(err)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] stop;
        int         ena_cycles;
        logic [2:0] load;
        logic [7:0] start;
    } exp_t;
    exp_t sb[$];

    int         ena_run = 0;
    logic [2:0] load_seen = '0;
    logic [7:0] data_seen = '0;

    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (load != '0) begin
                load_seen = load;
                data_seen = data;
                ena_run   = 0;
            end
            if (ena) ena_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 0);
                end else begin
                    e = sb.pop_front();
                    check("done_cnt", 32'(cnt), 32'(e.stop));
                    check("ena_cycles", ena_run, e.ena_cycles);
                    check("load_code", 32'(load_seen), 32'(e.load));
                    check("load_data", 32'(data_seen), 32'(e.start));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge of the LOAD_S cycle.
    task automatic send_cmd(input logic [7:0] s, input logic [7:0] p, input logic [2:0] m,
                            input bit push, input int exp_ena);
        bit ok;
        exp_t e;
        ok = 1'b0;
        cmd_start = s;
        cmd_stop  = p;
        cmd_mode  = m;
        cmd_valid = 1'b1;
        for (int i = 0; i < 1000 && !ok; i++) begin
            if (cmd_ready && !abort) begin
                if (push) begin
                    e.stop       = p;
                    e.ena_cycles = exp_ena;
                    e.load       = (m == 3'd0) ? 3'd1 : m;
                    e.start      = s;
                    sb.push_back(e);
                end
                ok = 1'b1;
            end
            @(negedge clock);
        end
        cmd_valid = 1'b0;
        if (!ok) check("cmd_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            if (cmd_ready && !busy && !done) ok = 1'b1;
            else @(negedge clock);
        end
        check(name, 32'(ok), 1);
    endtask

    typedef struct {
        logic [7:0] start, stop;
        logic [2:0] mode;
        int         ena_cycles;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit");
    end

    initial begin
        vecs[0] = '{8'h00, 8'h08, 3'd1, 8};
        vecs[1] = '{8'hFE, 8'h02, 3'd1, 4};
        vecs[2] = '{8'h20, 8'h23, 3'd5, 3};
        vecs[3] = '{8'h40, 8'h44, 3'd0, 4};
        vecs[4] = '{8'h10, 8'h0F, 3'd7, 255};
        vecs[5] = '{8'hFF, 8'h00, 3'd2, 1};

        repeat (2) @(negedge clock);
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_ena", 32'(ena), 0);
        check("rst_load", 32'(load), 0);
        check("rst_data", 32'(data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
`ifdef CNT_SEQ_WDOG_EN
        check("rst_err", 32'(err), 0);
`endif
        reset = 1'b0;
        #1 check("ready_before_edge", 32'(cmd_ready), 0);
        @(negedge clock);
        check("ready_after_reset", 32'(cmd_ready), 1);

        foreach (vecs[i]) begin
            send_cmd(vecs[i].start, vecs[i].stop, vecs[i].mode, 1'b1, vecs[i].ena_cycles);
            wait_idle("table_idle");
        end

        // start == stop: LOAD_S, RUN with no enable, then DONE_S
        send_cmd(8'h55, 8'h55, 3'd3, 1'b1, 0);
        check("ls_load", 32'(load), 3);
        check("ls_data", 32'(data), 'h55);
        check("ls_busy", 32'(busy), 1);
        check("ls_ena", 32'(ena), 0);
        check("ls_ready", 32'(cmd_ready), 0);
        @(negedge clock);
        check("run_ena", 32'(ena), 0);
        check("run_load", 32'(load), 0);
        check("run_data", 32'(data), 'h55);
        check("run_busy", 32'(busy), 1);
        check("run_done", 32'(done), 0);
        @(negedge clock);
        check("latency_done", 32'(done), 1);
        check("done_busy", 32'(busy), 0);
        check("done_ena", 32'(ena), 0);
        @(negedge clock);
        check("done_pulse_end", 32'(done), 0);
        check("ready_after_done", 32'(cmd_ready), 1);

        // Abort in the third RUN cycle, with a competing command held alongside
        send_cmd(8'h00, 8'h10, 3'd1, 1'b0, 0);
        repeat (3) @(negedge clock);
        check("abort_pre_ena", 32'(ena), 1);
        abort     = 1'b1;
        cmd_valid = 1'b1;
        cmd_start = 8'h77;
        cmd_stop  = 8'h78;
        cmd_mode  = 3'd1;
        @(negedge clock);
        check("abort_ena", 32'(ena), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_load", 32'(load), 0);
        check("abort_done", 32'(done), 0);
        @(negedge clock);
        check("abort_wins_busy", 32'(busy), 0);
        check("abort_wins_load", 32'(load), 0);
        abort     = 1'b0;
        cmd_valid = 1'b0;
        repeat (20) @(negedge clock);
        check("abort_idle_ena", 32'(ena), 0);
        check("abort_idle_ready", 32'(cmd_ready), 1);

        // A second command presented while busy waits until the first completes
        send_cmd(8'h00, 8'h04, 3'd1, 1'b1, 4);
        cmd_valid = 1'b1;
        cmd_start = 8'h30;
        cmd_stop  = 8'h32;
        cmd_mode  = 3'd2;
        @(negedge clock);
        check("holdoff_ready", 32'(cmd_ready), 0);
        send_cmd(8'h30, 8'h32, 3'd2, 1'b1, 2);
        wait_idle("holdoff_idle");
        check("holdoff_sb_empty", sb.size(), 0);

        // Abort during DONE_S: the pulse already seen still completes
        send_cmd(8'h66, 8'h66, 3'd1, 1'b1, 0);
        repeat (2) @(negedge clock);
        check("dabort_done", 32'(done), 1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("dabort_done_clr", 32'(done), 0);
        check("dabort_ready", 32'(cmd_ready), 1);

        // Reset in the middle of a run
        send_cmd(8'h00, 8'h40, 3'd1, 1'b0, 0);
        repeat (3) @(negedge clock);
        check("midrst_pre_ena", 32'(ena), 1);
        reset = 1'b1;
        #1;
        check("midrst_ena", 32'(ena), 0);
        check("midrst_load", 32'(load), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_ready", 32'(cmd_ready), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_ready_back", 32'(cmd_ready), 1);
        repeat (5) @(negedge clock);
        check("midrst_no_busy", 32'(busy), 0);

`ifdef CNT_SEQ_WDOG_EN
        // Stuck counter: watchdog fires after 16 RUN cycles
        cnt_stuck = 1'b1;
        send_cmd(8'h00, 8'h05, 3'd1, 1'b0, 0);
        repeat (16) @(negedge clock);
        check("wdog_busy_16", 32'(busy), 1);
        check("wdog_err_16", 32'(err), 0);
        @(negedge clock);
        check("wdog_err", 32'(err), 1);
        check("wdog_done", 32'(done), 0);
        check("wdog_ena", 32'(ena), 0);
        check("wdog_busy", 32'(busy), 0);
        @(negedge clock);
        check("wdog_err_pulse", 32'(err), 0);
        check("wdog_ready", 32'(cmd_ready), 1);
        cnt_stuck = 1'b0;
`endif

        check("final_sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
